// File: rtl/sar_mag_search_pkg.sv
// Shared definitions for the successive-approximation magnitude search controller.
package sar_mag_search_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSearch = 2'd1,
        StDone   = 2'd2
    } state_e;

    // Bit positions inside the {AeqB, AgtB, AltB} flag vector.
    localparam int unsigned FlagEq = 2;
    localparam int unsigned FlagGt = 1;
    localparam int unsigned FlagLt = 0;

    function automatic logic flags_onehot(input logic [2:0] f);
        return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
    endfunction

endpackage

// File: rtl/sar_mag_search.sv
// Binary-searches a target seen only through comparator flags, one bit per cycle, MSB first.
module sar_mag_search
    import sar_mag_search_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             AeqB,
    input  logic             AgtB,
    input  logic             AltB,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] KMax = KW'(WIDTH - 1);

    state_e           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic [KW-1:0]    r_k;
    logic             r_err;

    logic [2:0]       w_flags;
    logic [WIDTH-1:0] w_bit;
    logic [WIDTH-1:0] w_trial;
    logic             w_keep_bit;
    logic [WIDTH-1:0] w_acc_next;

    assign w_flags = {AeqB, AgtB, AltB};
    assign w_bit   = WIDTH'(1) << r_k;
    assign w_trial = r_acc | w_bit;

    // AltB on the last bit cannot happen with a sane comparator; treat it like AgtB.
    assign w_keep_bit = w_flags[FlagLt] && !w_flags[FlagGt] && (r_k != '0);
    assign w_acc_next = w_keep_bit ? w_trial : r_acc;

    assign guess  = (r_state == StSearch) ? w_trial : '0;
    assign busy   = (r_state == StSearch);
    assign done   = (r_state == StDone);
    assign err    = r_err;
    assign result = r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_acc    <= '0;
            r_k      <= KMax;
            r_err    <= 1'b0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_state <= StSearch;
                        r_acc   <= '0;
                        r_k     <= KMax;
                        r_err   <= 1'b0;
                    end
                end
                StSearch: begin
                    if (!flags_onehot(w_flags)) begin
                        r_err    <= 1'b1;
                        r_result <= r_acc;
                        r_state  <= StDone;
                    end else if (w_flags[FlagEq]) begin
                        r_result <= w_trial;
                        r_state  <= StDone;
                    end else if (r_k == '0) begin
                        r_result <= w_acc_next;
                        r_state  <= StDone;
                    end else begin
                        r_acc <= w_acc_next;
                        r_k   <= r_k - 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_mag_search.sv
// Self-checking bench: random and swept targets against a plain-arithmetic binary-search model.
module tb_sar_mag_search;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             AeqB;
    logic             AgtB;
    logic             AltB;
    logic [WIDTH-1:0] guess;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    logic [WIDTH-1:0] target;
    logic             force_en;
    logic [2:0]       force_val;

    int n_checks;
    int n_errors;

    sar_mag_search #(
        .WIDTH(WIDTH)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .AeqB  (AeqB),
        .AgtB  (AgtB),
        .AltB  (AltB),
        .guess (guess),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .result(result)
    );

    // Comparator with a = guess, b = target, plus an override for illegal flags.
    always_comb begin
        if (force_en) begin
            {AeqB, AgtB, AltB} = force_val;
        end else begin
            AeqB = (guess == target);
            AgtB = (guess > target);
            AltB = (guess < target);
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: classic MSB-first binary search over [0, 2^WIDTH).
    task automatic model_guesses(input int t, output int seq[$]);
        int lo;
        int g;
        seq = {};
        lo  = 0;
        for (int b = WIDTH - 1; b >= 0; b--) begin
            g = lo + (1 << b);
            seq.push_back(g);
            if (g == t) break;
            if (g < t) lo = g;
        end
    endtask

    // Full search with guess-by-guess checking; optionally pulses start while busy/done.
    task automatic run_search(input int t, input bit start_while_busy);
        int seq[$];
        model_guesses(t, seq);
        target = WIDTH'(t);
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < seq.size(); i++) begin
            check("busy_in_search", busy, 1);
            check("guess", guess, seq[i]);
            check("done_low_in_search", done, 0);
            if (start_while_busy && i > 0) start = 1'b1;
            tick();
        end
        if (start_while_busy) start = 1'b1;
        check("done_pulse", done, 1);
        check("result", result, t);
        check("err_clear", err, 0);
        check("busy_low_in_done", busy, 0);
        check("guess_zero_in_done", guess, 0);
        tick();
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("result_held", result, t);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        target    = '0;
        force_en  = 1'b0;
        force_val = 3'b000;
        #12;
        check("rst_guess", guess, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_result", result, 0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        run_search(0, 1'b0);
        run_search(8, 1'b0);
        run_search(5, 1'b0);
        run_search(15, 1'b0);
        for (int t = 0; t < (1 << WIDTH); t++) run_search(t, 1'b0);
        for (int n = 0; n < 20; n++) run_search(int'($urandom_range(0, (1 << WIDTH) - 1)), 1'b0);

        // Illegal flags on the first search cycle.
        target = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
        start  = 1'b1;
        tick();
        start     = 1'b0;
        force_en  = 1'b1;
        force_val = 3'b000;
        check("force_busy", busy, 1);
        tick();
        force_en = 1'b0;
        check("force_done", done, 1);
        check("force_err", err, 1);
        check("force_result", result, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("err_held", err, 1);
            check("force_done_once", done, 0);
        end
        run_search(int'($urandom_range(0, (1 << WIDTH) - 1)), 1'b0);

        // Start requests while busy must be ignored.
        run_search(5, 1'b1);
        for (int n = 0; n < 6; n++) run_search(int'($urandom_range(0, (1 << WIDTH) - 1)), 1'b1);
        run_search(5, 1'b0);

        // Reset during the second search cycle aborts silently.
        target = 4'd5;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_guess", guess, 0);
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        check("abort_done", done, 0);
        tick();
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("no_done_after_abort", done, 0);
        end
        run_search(11, 1'b0);
        run_search(int'($urandom_range(0, (1 << WIDTH) - 1)), 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
